// File: rtl/cpu_pkg.sv
// Shared core definitions used by the divider.
// Contents:
//   OP_DIV..OP_REMU : func3 encodings of the M-extension divide group
//   DivCycles       : iteration count of the 32-bit divider
//   div_state_t     : divider FSM states
//   is_signed_op / is_rem_op : func3 decode helpers
package cpu_pkg;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    localparam int DivCycles = 32;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_t;

    // DIV and REM are signed (func3[0] clear); REM/REMU return the remainder (func3[1] set).
    function automatic logic is_signed_op(input logic [2:0] func3);
        return ~func3[0];
    endfunction

    function automatic logic is_rem_op(input logic [2:0] func3);
        return func3[1];
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// Ports:
//   rem      : partial remainder, always below divisor
//   quo      : dividend bits still to shift in (MSB first), quotient bits fill from the LSB
//   divisor  : magnitude of the divisor
//   next_rem : partial remainder after this iteration
//   next_quo : quo shifted left with the new quotient bit in the LSB
module mdu_div_step #(
    parameter int DataWidth = 32
) (
    input  logic [DataWidth-1:0] rem,
    input  logic [DataWidth-1:0] quo,
    input  logic [DataWidth-1:0] divisor,
    output logic [DataWidth-1:0] next_rem,
    output logic [DataWidth-1:0] next_quo
);

    logic [DataWidth:0] shifted;
    logic [DataWidth:0] diff;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        shifted = {rem, quo[DataWidth-1]};
        diff    = shifted - {1'b0, divisor};
        // rem < divisor bounds shifted below 2*divisor, so the top bit of
        // the difference is a clean borrow flag for the trial subtract.
        if (diff[DataWidth]) begin
            next_rem = shifted[DataWidth-1:0];
            next_quo = {quo[DataWidth-2:0], 1'b0};
        end else begin
            next_rem = diff[DataWidth-1:0];
            next_quo = {quo[DataWidth-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_div_unit.sv
// Multi-cycle iterative divider for DIV/DIVU/REM/REMU in the EX stage.
// Ports:
//   clk, rstn : core clock, asynchronous active-low reset
//   start_i   : issue request, sampled only when idle
//   func3_i   : OP_DIV / OP_DIVU / OP_REM / OP_REMU
//   src1_i    : dividend (rs1)
//   src2_i    : divisor (rs2)
//   flush_i   : squash the operation in flight, masks start_i when idle
//   busy_o    : pipeline stall, high from the cycle after acceptance until done_o
//   done_o    : one-cycle pulse, result_o valid
//   result_o  : quotient or remainder, held until the next result
module mdu_div_unit
    import cpu_pkg::*;
#(
    parameter int DataWidth = DivCycles,
    parameter int CntWidth  = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic [2:0]           func3_i,
    input  logic [DataWidth-1:0] src1_i,
    input  logic [DataWidth-1:0] src2_i,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DataWidth-1:0] result_o
);

    div_state_t           state;
    logic [CntWidth-1:0]  cnt;
    logic                 rem_sel;
    logic                 neg_quo;
    logic                 neg_rem;
    logic [DataWidth-1:0] rem_q;
    logic [DataWidth-1:0] quo_q;
    logic [DataWidth-1:0] div_q;
    logic [DataWidth-1:0] next_rem;
    logic [DataWidth-1:0] next_quo;

    logic                 op_signed;
    logic                 src1_neg;
    logic                 src2_neg;
    logic                 div_zero;
    logic                 overflow;
    logic [DataWidth-1:0] abs1;
    logic [DataWidth-1:0] abs2;
    logic [DataWidth-1:0] quo_fix;
    logic [DataWidth-1:0] rem_fix;

    mdu_div_step #(.DataWidth(DataWidth)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_q),
        .next_rem (next_rem),
        .next_quo (next_quo)
    );

    // Operand preparation at issue and sign fix-up at completion.
    always_comb begin
        op_signed = is_signed_op(func3_i);
        src1_neg  = op_signed & src1_i[DataWidth-1];
        src2_neg  = op_signed & src2_i[DataWidth-1];
        abs1      = src1_neg ? -src1_i : src1_i;
        abs2      = src2_neg ? -src2_i : src2_i;
        div_zero  = (src2_i == '0);
        overflow  = op_signed && (src1_i == {1'b1, {(DataWidth-1){1'b0}}})
                              && (src2_i == '1);
        quo_fix   = neg_quo ? -quo_q : quo_q;
        rem_fix   = neg_rem ? -rem_q : rem_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= DIV_IDLE;
            cnt      <= '0;
            rem_sel  <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start_i && !flush_i) begin
                        rem_sel <= is_rem_op(func3_i);
                        busy_o  <= 1'b1;
                        cnt     <= CntWidth'(DataWidth - 1);
                        div_q   <= abs2;
                        // Special cases preload the final quotient/remainder
                        // with sign fix-up disabled and skip the iterations.
                        if (div_zero) begin
                            quo_q   <= '1;
                            rem_q   <= src1_i;
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                            state   <= DIV_DONE;
                        end else if (overflow) begin
                            quo_q   <= src1_i;
                            rem_q   <= '0;
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                            state   <= DIV_DONE;
                        end else begin
                            quo_q   <= abs1;
                            rem_q   <= '0;
                            neg_quo <= src1_neg ^ src2_neg;
                            neg_rem <= src1_neg;
                            state   <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    if (flush_i) begin
                        state  <= DIV_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        rem_q <= next_rem;
                        quo_q <= next_quo;
                        // Exit test precedes the decrement, so the counter stops at zero.
                        if (cnt == '0) begin
                            state <= DIV_DONE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                DIV_DONE: begin
                    state  <= DIV_IDLE;
                    busy_o <= 1'b0;
                    if (!flush_i) begin
                        done_o   <= 1'b1;
                        result_o <= rem_sel ? rem_fix : quo_fix;
                    end
                end
                default: begin
                    state  <= DIV_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_div_unit.sv
module tb_mdu_div_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  func3_i = OP_DIV;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [31:0] last_result = '0;

    mdu_div_unit dut (
        .clk      (clk),
        .rstn     (rstn),
        .start_i  (start_i),
        .func3_i  (func3_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done_o === 1'b1) done_cnt++;

    // Reference: RISC-V division semantics in plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        logic [63:0] r64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        if (b == 32'h0) return (f3 == OP_DIV || f3 == OP_DIVU) ? 32'hFFFF_FFFF : a;
        if ((f3 == OP_DIV || f3 == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (f3 == OP_DIV) ? 32'h8000_0000 : 32'h0;
        case (f3)
            OP_DIV:  r = sa / sb;
            OP_REM:  r = sa % sb;
            OP_DIVU: r = ua / ub;
            default: r = ua % ub;
        endcase
        r64 = r;
        return r64[31:0];
    endfunction

    function automatic int model_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0) return 1;
        if ((f3 == OP_DIV || f3 == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one operation and wait (bounded) for done_o. With poke set,
    // random start/operand activity is driven while the unit is busy.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit poke, output logic [31:0] res, output int lat, output bit busy_ok);
        @(negedge clk);
        func3_i = f3; src1_i = a; src2_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = 0; busy_ok = 1'b1; res = 32'hx;
        if (busy_o !== 1'b1) busy_ok = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (poke) begin
                start_i = 1'($urandom_range(0, 1));
                src1_i  = 32'($urandom);
                src2_i  = 32'($urandom);
                func3_i = 3'($urandom_range(4, 7));
            end
            @(posedge clk); #1;
            if (done_o === 1'b1) begin
                lat = i; res = result_o; start_i = 1'b0;
                if (busy_o !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy_o !== 1'b1) busy_ok = 1'b0;
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b result=%h required 0/0/00000000", busy_o, done_o, result_o);
        end
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: busy=%b done=%b required 0/0", busy_o, done_o);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  f3 [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [31:0] a  [4] = '{32'h14, 32'h14, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] b  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h2, 32'h2};
        logic [31:0] e  [4] = '{32'hFFFF_FFFA, 32'h2, 32'h7FFF_FFFF, 32'h1};
        logic [31:0] res;
        int lat;
        bit busy_ok;
        for (int i = 0; i < 4; i++) begin
            run_op(f3[i], a[i], b[i], i >= 2, res, lat, busy_ok);
            checks++;
            if (res !== e[i]) begin
                failures++;
                $display("FAIL directed_result[%0d]: got %h required %h", i, res, e[i]);
            end
            checks++;
            if (lat != 33) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d required 33", i, lat);
            end
            checks++;
            if (!busy_ok) begin
                failures++;
                $display("FAIL directed_busy[%0d]: busy_o not high for whole operation", i);
            end
            last_result = e[i];
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3 [4] = '{OP_DIV, OP_REM, OP_DIV, OP_REM};
        logic [31:0] a  [4] = '{32'h7, 32'h7, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b  [4] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] e  [4] = '{32'hFFFF_FFFF, 32'h7, 32'h8000_0000, 32'h0};
        logic [31:0] res;
        int lat;
        bit busy_ok;
        for (int i = 0; i < 4; i++) begin
            run_op(f3[i], a[i], b[i], 1'b0, res, lat, busy_ok);
            checks++;
            if (res !== e[i] || lat != 1) begin
                failures++;
                $display("FAIL special[%0d]: got %h after %0d required %h after 1", i, res, lat, e[i]);
            end
            last_result = e[i];
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, d0;
        bit busy_ok;
        // flush together with start in IDLE is not an acceptance
        @(negedge clk);
        func3_i = OP_DIVU; src1_i = 32'd50; src2_i = 32'd3; start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_masks_start: busy=%b required 0", busy_o);
        end
        d0 = done_cnt;
        @(negedge clk);
        func3_i = OP_DIV; src1_i = 32'($urandom); src2_i = 32'd5; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== last_result) begin
            failures++;
            $display("FAIL flush_calc: busy=%b done=%b result=%h required 0/0/%h", busy_o, done_o, result_o, last_result);
        end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL flush_no_done: done pulses %0d required 0", done_cnt - d0);
        end
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, res, lat, busy_ok);
        checks++;
        if (res !== 32'd14 || lat != 33) begin
            failures++;
            $display("FAIL after_flush: got %h after %0d required 0000000e after 33", res, lat);
        end
        last_result = 32'd14;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int lat, d0;
        bit busy_ok;
        @(negedge clk);
        func3_i = OP_REMU; src1_i = 32'($urandom); src2_i = 32'd9; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h required 0/0/00000000", busy_o, done_o, result_o);
        end
        d0 = done_cnt;
        @(negedge clk) rstn = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != d0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_quiet: done pulses %0d busy=%b required 0/0", done_cnt - d0, busy_o);
        end
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, res, lat, busy_ok);
        checks++;
        if (res !== 32'hFFFF_FFFF || lat != 33) begin
            failures++;
            $display("FAIL rem_after_reset: got %h after %0d required ffffffff after 33", res, lat);
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res, exp;
        int lat, exp_lat, d0;
        bit busy_ok;
        d0 = done_cnt;
        for (int n = 0; n < 1200; n++) begin
            f3 = 3'($urandom_range(4, 7));
            a = pick_operand();
            b = pick_operand();
            exp = model(f3, a, b);
            exp_lat = model_latency(f3, a, b);
            run_op(f3, a, b, 1'($urandom_range(0, 1)), res, lat, busy_ok);
            checks++;
            if (res !== exp || lat != exp_lat || !busy_ok) begin
                failures++;
                $display("FAIL random[%0d] f3=%0d %h/%h: got %h lat %0d busy_ok %0d required %h lat %0d busy_ok 1",
                         n, f3, a, b, res, lat, busy_ok, exp, exp_lat);
            end
        end
        @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1200) begin
            failures++;
            $display("FAIL random_done_count: got %0d required 1200", done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
